mmu_tlb: RTL and testbench

Parametrised successor to the fixed-mapping address translator: translates 32-bit MIPS virtual addresses to physical addresses and cacheability with a registered one-cycle lookup. kseg0/kseg1 keep the fixed mapping. kuseg and kseg2/3 are mapped through a software-managed, fully associative TLB of configurable depth. The block supports TLBP, TLBR and TLBWI. It sits between the EX/MEM address path (and IF for fetch) and the cache/bus interface; a legacy mode keeps the old identity mapping.

---
 rtl/mmu_tlb.sv | 220 ++++++++++++++++++++++
 tb/tb_mmu_tlb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tlb.sv
// mmu_tlb: MIPS VA->PA translator, fixed kseg0/kseg1 plus a fully
// associative software-managed TLB (TLBP/TLBR/TLBWI), 1-cycle lookup.
// Ports: clk/resetn (sync, active-low); stall; req_* lookup in,
// rsp_* lookup out (paddr, cache, refill/invalid/modified);
// tlb_op/index_i/entry*_i op in; op_done, probe_*, rd_* op out.
module mmu_tlb #(
    parameter int TLB_ENTRIES = 16,
    parameter bit USE_TLB     = 1'b1,
    parameter bit K0_CACHED   = 1'b1,
    localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             req_valid,
    input  logic [31:0]      req_vaddr,
    input  logic             req_store,
    input  logic [7:0]       cur_asid,
    output logic             rsp_valid,
    output logic [31:0]      rsp_paddr,
    output logic             rsp_cache,
    output logic             rsp_refill,
    output logic             rsp_invalid,
    output logic             rsp_modified,
    input  logic [1:0]       tlb_op,
    input  logic [IDX_W-1:0] index_i,
    input  logic [31:0]      entryhi_i,
    input  logic [31:0]      entrylo0_i,
    input  logic [31:0]      entrylo1_i,
    output logic             op_done,
    output logic             probe_miss,
    output logic [IDX_W-1:0] probe_index,
    output logic [31:0]      rd_entryhi,
    output logic [31:0]      rd_entrylo0,
    output logic [31:0]      rd_entrylo1
);

    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;

    typedef struct packed {
        logic        present;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    tlb_entry_t ent [TLB_ENTRIES];

    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:8],
                           entrylo0_i[31:26],
                           entrylo1_i[31:26]};

    function automatic logic hit_f(
        input tlb_entry_t e,
        input logic [18:0] vpn2,
        input logic [7:0]  asid
    );
        return e.present && (e.vpn2 == vpn2) &&
               (e.g || (e.asid == asid));
    endfunction

    // Scan from the top so the lowest matching index wins.
    logic             l_hit;
    logic [IDX_W-1:0] l_idx;
    logic             p_hit;
    logic [IDX_W-1:0] p_idx;

    always_comb begin
        l_hit = 1'b0;
        l_idx = '0;
        p_hit = 1'b0;
        p_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (hit_f(ent[i], req_vaddr[31:13], cur_asid)) begin
                l_hit = 1'b1;
                l_idx = i[IDX_W-1:0];
            end
            if (hit_f(ent[i], entryhi_i[31:13],
                      entryhi_i[7:0])) begin
                p_hit = 1'b1;
                p_idx = i[IDX_W-1:0];
            end
        end
    end

    tlb_entry_t  le;
    logic [19:0] s_pfn;
    logic [2:0]  s_c;
    logic        s_d;
    logic        s_v;

    always_comb begin
        le    = ent[l_idx];
        s_pfn = req_vaddr[12] ? le.pfn1 : le.pfn0;
        s_c   = req_vaddr[12] ? le.c1   : le.c0;
        s_d   = req_vaddr[12] ? le.d1   : le.d0;
        s_v   = req_vaddr[12] ? le.v1   : le.v0;
    end

    logic is_k0;
    logic is_k1;
    logic mapped;

    assign is_k0  = req_vaddr[31:29] == 3'b100;
    assign is_k1  = req_vaddr[31:29] == 3'b101;
    assign mapped = !is_k0 && !is_k1;

    logic [31:0] n_paddr;
    logic        n_cache;
    logic        n_refill;
    logic        n_inv;
    logic        n_mod;

    always_comb begin
        n_paddr  = '0;
        n_cache  = 1'b0;
        n_refill = 1'b0;
        n_inv    = 1'b0;
        n_mod    = 1'b0;
        unique case (1'b1)
            is_k0: begin
                n_paddr = {3'b000, req_vaddr[28:0]};
                n_cache = K0_CACHED;
            end
            is_k1: begin
                n_paddr = {3'b000, req_vaddr[28:0]};
            end
            mapped && !USE_TLB: begin
                n_paddr = req_vaddr;
                n_cache = 1'b1;
            end
            mapped && USE_TLB && !l_hit: begin
                n_refill = 1'b1;
            end
            mapped && USE_TLB && l_hit: begin
                n_paddr = {s_pfn, req_vaddr[11:0]};
                n_cache = s_c == 3'b011;
                n_inv   = !s_v;
                n_mod   = s_v && !s_d && req_store;
            end
            default: ;
        endcase
    end

    tlb_entry_t we;
    tlb_entry_t re;

    always_comb begin
        we         = '0;
        we.present = 1'b1;
        we.vpn2    = entryhi_i[31:13];
        we.asid    = entryhi_i[7:0];
        we.g       = entrylo0_i[0] & entrylo1_i[0];
        we.pfn0    = entrylo0_i[25:6];
        we.c0      = entrylo0_i[5:3];
        we.d0      = entrylo0_i[2];
        we.v0      = entrylo0_i[1];
        we.pfn1    = entrylo1_i[25:6];
        we.c1      = entrylo1_i[5:3];
        we.d1      = entrylo1_i[2];
        we.v1      = entrylo1_i[1];
        re         = ent[index_i];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_ENTRIES; i++)
                ent[i] <= '0;
            rsp_valid    <= 1'b0;
            rsp_paddr    <= '0;
            rsp_cache    <= 1'b0;
            rsp_refill   <= 1'b0;
            rsp_invalid  <= 1'b0;
            rsp_modified <= 1'b0;
            op_done      <= 1'b0;
            probe_miss   <= 1'b0;
            probe_index  <= '0;
            rd_entryhi   <= '0;
            rd_entrylo0  <= '0;
            rd_entrylo1  <= '0;
        end else begin
            if (!stall) begin
                rsp_valid <= req_valid;
                if (req_valid) begin
                    rsp_paddr    <= n_paddr;
                    rsp_cache    <= n_cache;
                    rsp_refill   <= n_refill;
                    rsp_invalid  <= n_inv;
                    rsp_modified <= n_mod;
                end
            end
            op_done <= tlb_op != 2'b00;
            if (tlb_op == OP_TLBP) begin
                probe_miss  <= !p_hit;
                probe_index <= p_idx;
            end
            if (tlb_op == OP_TLBR) begin
                rd_entryhi  <= {re.vpn2, 5'b0, re.asid};
                rd_entrylo0 <= {6'b0, re.pfn0, re.c0,
                                re.d0, re.v0, re.g};
                rd_entrylo1 <= {6'b0, re.pfn1, re.c1,
                                re.d1, re.v1, re.g};
            end
            if (tlb_op == OP_TLBWI)
                ent[index_i] <= we;
        end
    end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed table-driven bench for mmu_tlb plus hand
// sequences for op timing, write ordering, stall, reset, USE_TLB=0.
module tb_mmu_tlb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        req_valid;
    logic [31:0] req_vaddr;
    logic        req_store;
    logic [7:0]  cur_asid;
    logic [1:0]  tlb_op;
    logic [3:0]  index_i;
    logic [31:0] entryhi_i;
    logic [31:0] entrylo0_i;
    logic [31:0] entrylo1_i;

    logic        rsp_valid, rsp_cache, rsp_refill;
    logic        rsp_invalid, rsp_modified;
    logic [31:0] rsp_paddr;
    logic        op_done, probe_miss;
    logic [3:0]  probe_index;
    logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1;

    logic        f_valid, f_cache, f_refill, f_inv, f_mod;
    logic [31:0] f_paddr;
    logic        f_done, f_pmiss;
    logic [3:0]  f_pidx;
    logic [31:0] f_rhi, f_rlo0, f_rlo1;

    always #5 clk = ~clk;

    mmu_tlb #(.TLB_ENTRIES(16), .USE_TLB(1'b1),
              .K0_CACHED(1'b1)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .req_valid(req_valid), .req_vaddr(req_vaddr),
        .req_store(req_store), .cur_asid(cur_asid),
        .rsp_valid(rsp_valid), .rsp_paddr(rsp_paddr),
        .rsp_cache(rsp_cache), .rsp_refill(rsp_refill),
        .rsp_invalid(rsp_invalid),
        .rsp_modified(rsp_modified),
        .tlb_op(tlb_op), .index_i(index_i),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .op_done(op_done),
        .probe_miss(probe_miss), .probe_index(probe_index),
        .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0),
        .rd_entrylo1(rd_entrylo1)
    );

    mmu_tlb #(.TLB_ENTRIES(16), .USE_TLB(1'b0),
              .K0_CACHED(1'b1)) dut_fix (
        .clk(clk), .resetn(resetn), .stall(stall),
        .req_valid(req_valid), .req_vaddr(req_vaddr),
        .req_store(req_store), .cur_asid(cur_asid),
        .rsp_valid(f_valid), .rsp_paddr(f_paddr),
        .rsp_cache(f_cache), .rsp_refill(f_refill),
        .rsp_invalid(f_inv), .rsp_modified(f_mod),
        .tlb_op(tlb_op), .index_i(index_i),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .op_done(f_done),
        .probe_miss(f_pmiss), .probe_index(f_pidx),
        .rd_entryhi(f_rhi), .rd_entrylo0(f_rlo0),
        .rd_entrylo1(f_rlo1)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  idx;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        logic [31:0] va;
        logic        st;
        logic [7:0]  asid;
        logic [31:0] pa;
        logic        ca;
        logic        rf;
        logic        iv;
        logic        md;
    } vec_t;

    vec_t tv [12];
    int   nvec = 0;
    int   nmis = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rsp_bits();
        return {27'd0, rsp_valid, rsp_cache, rsp_refill,
                rsp_invalid, rsp_modified, rsp_paddr};
    endfunction

    function automatic logic [63:0] exp_bits(
        input logic ca, input logic rf, input logic iv,
        input logic md, input logic [31:0] pa);
        return {27'd0, 1'b1, ca, rf, iv, md, pa};
    endfunction

    task automatic idle();
        stall     = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        tlb_op    = 2'b00;
    endtask

    task automatic drive_op(input logic [1:0] op,
                            input logic [3:0] idx,
                            input logic [31:0] hi,
                            input logic [31:0] lo0,
                            input logic [31:0] lo1);
        tlb_op     = op;
        index_i    = idx;
        entryhi_i  = hi;
        entrylo0_i = lo0;
        entrylo1_i = lo1;
    endtask

    task automatic drive_req(input logic [31:0] va,
                             input logic st,
                             input logic [7:0] asid);
        req_valid = 1'b1;
        req_vaddr = va;
        req_store = st;
        cur_asid  = asid;
    endtask

    initial begin
        // PFN 0x12345 C=3 D=1 V=1 -> 0x48D15E (+G -> 0x48D15F)
        // PFN 0x00ABC C=2 -> 0x2AF10 (V=1 -> 0x2AF12)
        tv[0]  = '{0, 0, 0, 0, 0, 32'h0000_1000, 0, 8'd0,
                   32'h0, 0, 1, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 32'h9FC0_0000, 0, 8'd0,
                   32'h1FC0_0000, 1, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 8'd0,
                   32'h1FC0_0000, 0, 0, 0, 0};
        tv[3]  = '{1, 3, 32'h0040_0005, 32'h0048_D15E, 32'h0,
                   32'h0040_0ABC, 0, 8'd5,
                   32'h1234_5ABC, 1, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 32'h0040_0ABC, 0, 8'd6,
                   32'h0, 0, 1, 0, 0};
        tv[5]  = '{1, 3, 32'h0040_0005, 32'h0048_D15F,
                   32'h0000_0001, 32'h0040_0ABC, 0, 8'd6,
                   32'h1234_5ABC, 1, 0, 0, 0};
        tv[6]  = '{1, 1, 32'h0040_0009, 32'h0, 32'h0002_AF10,
                   32'h0040_1000, 0, 8'd9,
                   32'h00AB_C000, 0, 0, 1, 0};
        tv[7]  = '{1, 1, 32'h0040_0009, 32'h0, 32'h0002_AF12,
                   32'h0040_1000, 1, 8'd9,
                   32'h00AB_C000, 0, 0, 0, 1};
        tv[8]  = '{0, 0, 0, 0, 0, 32'h0040_1000, 0, 8'd9,
                   32'h00AB_C000, 0, 0, 0, 0};
        tv[9]  = '{0, 0, 0, 0, 0, 32'h0040_0ABC, 0, 8'd9,
                   32'h0000_0ABC, 0, 0, 1, 0};
        tv[10] = '{0, 0, 0, 0, 0, 32'hC000_1234, 0, 8'd0,
                   32'h0, 0, 1, 0, 0};
        tv[11] = '{0, 0, 0, 0, 0, 32'h0040_1000, 0, 8'd6,
                   32'h0, 0, 0, 1, 0};

        resetn = 1'b0;
        idle();
        drive_op(2'b00, 4'd0, 32'h0, 32'h0, 32'h0);
        req_vaddr = 32'h0;
        cur_asid  = 8'h0;
        repeat (2) @(negedge clk);
        chk("reset_rsp", rsp_bits(), 64'h0);
        chk("reset_ops",
            {op_done, probe_miss, probe_index, rd_entryhi},
            38'h0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (tv[i].wr) begin
                drive_op(2'b11, tv[i].idx, tv[i].hi,
                         tv[i].lo0, tv[i].lo1);
                @(negedge clk);
                tlb_op = 2'b00;
            end
            drive_req(tv[i].va, tv[i].st, tv[i].asid);
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("vec%0d", i), rsp_bits(),
                exp_bits(tv[i].ca, tv[i].rf, tv[i].iv,
                         tv[i].md, tv[i].pa));
        end

        drive_op(2'b01, 4'd0, 32'h0040_0005, 32'h0, 32'h0);
        @(negedge clk);
        tlb_op = 2'b00;
        chk("tlbp_hit", {op_done, probe_miss, probe_index},
            {1'b1, 1'b0, 4'd3});
        @(negedge clk);
        chk("op_done_pulse", {63'd0, op_done}, 64'd0);
        chk("probe_hold", {probe_miss, probe_index},
            {1'b0, 4'd3});

        drive_op(2'b01, 4'd0, 32'h7FFF_E005, 32'h0, 32'h0);
        @(negedge clk);
        tlb_op = 2'b00;
        chk("tlbp_miss", {op_done, probe_miss, probe_index},
            {1'b1, 1'b1, 4'd0});

        drive_op(2'b10, 4'd3, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        tlb_op = 2'b00;
        chk("tlbr_3", {rd_entryhi, rd_entrylo0, rd_entrylo1},
            {32'h0040_0005, 32'h0048_D15F, 32'h0000_0001});

        drive_op(2'b10, 4'd7, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        tlb_op = 2'b00;
        chk("tlbr_empty", {rd_entryhi, rd_entrylo0, rd_entrylo1},
            96'h0);

        // TLBWI and lookup on the same edge, then TLBR + lookup
        drive_op(2'b11, 4'd5, 32'h1234_0007, 32'h0155_555E,
                 32'h0);
        drive_req(32'h1234_0678, 1'b0, 8'd7);
        @(negedge clk);
        chk("same_edge_refill", rsp_bits(),
            exp_bits(0, 1, 0, 0, 32'h0));
        tlb_op  = 2'b10;
        @(negedge clk);
        tlb_op  = 2'b00;
        chk("next_cycle_hit", rsp_bits(),
            exp_bits(1, 0, 0, 0, 32'h5555_5678));
        chk("tlbr_after_wi",
            {op_done, rd_entryhi, rd_entrylo0, rd_entrylo1},
            {1'b1, 32'h1234_0007, 32'h0155_555E, 32'h0});

        stall     = 1'b1;
        req_vaddr = 32'h9FC0_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", k), rsp_bits(),
                exp_bits(1, 0, 0, 0, 32'h5555_5678));
        end
        stall     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_no_valid", {63'd0, rsp_valid}, 64'd0);

        drive_req(32'hC000_1234, 1'b0, 8'd0);
        @(negedge clk);
        chk("fixed_kseg2",
            {27'd0, f_valid, f_cache, f_refill, f_inv, f_mod,
             f_paddr},
            exp_bits(1, 0, 0, 0, 32'hC000_1234));
        drive_req(32'h0040_0ABC, 1'b1, 8'd3);
        @(negedge clk);
        req_valid = 1'b0;
        chk("fixed_kuseg",
            {27'd0, f_valid, f_cache, f_refill, f_inv, f_mod,
             f_paddr},
            exp_bits(1, 0, 0, 0, 32'h0040_0ABC));

        resetn = 1'b0;
        drive_op(2'b11, 4'd6, 32'h0080_0000, 32'h0155_555F,
                 32'h0000_0001);
        @(negedge clk);
        chk("reset_drops_op", {63'd0, op_done}, 64'd0);
        resetn = 1'b1;
        drive_op(2'b10, 4'd6, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        tlb_op = 2'b00;
        chk("reset_entry_gone",
            {op_done, rd_entryhi, rd_entrylo0, rd_entrylo1},
            {1'b1, 96'h0});
        drive_req(32'h0080_0000, 1'b0, 8'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("reset_lookup_refill", rsp_bits(),
            exp_bits(0, 1, 0, 0, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule
